// File: rtl/pll_cfg_pkg.sv
// Purpose : shared AHB encodings, PLL register map and the fixed PLL
//           reconfiguration step table used by ahb_pll_cfg_manager.
// Ports   : none (package); step_decode() is purely combinational.
package pll_cfg_pkg;

   typedef enum logic [1:0] {
      HTRANS_IDLE   = 2'b00,
      HTRANS_BUSY   = 2'b01,
      HTRANS_NONSEQ = 2'b10,
      HTRANS_SEQ    = 2'b11
   } htrans_t;

   localparam logic [2:0] HSIZE_WORD      = 3'b010;
   localparam logic [2:0] HBURST_SINGLE   = 3'b000;
   localparam logic [3:0] HPROT_PRIV_DATA = 4'b0011;

   // PLL subordinate register map (offsets from its base address)
   localparam logic [31:0] PLL_KP_OFFSET = 32'h0;
   localparam logic [31:0] PLL_KI_OFFSET = 32'h4;
   localparam logic [31:0] PLL_N_OFFSET  = 32'h8;
   localparam logic [31:0] PLL_EN_OFFSET = 32'hC;

   typedef enum logic [1:0] {
      ERR_NONE     = 2'd0,
      ERR_HRESP    = 2'd1,
      ERR_MISMATCH = 2'd2
   } err_code_t;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2,
      ST_FIN  = 2'd3
   } cfg_state_t;

   typedef enum logic [1:0] {
      REG_KP = 2'd0,
      REG_KI = 2'd1,
      REG_N  = 2'd2,
      REG_EN = 2'd3
   } pll_reg_t;

   // One entry of the sequence. For writes, data is the value to write;
   // for reads, data is the value the readback must match.
   typedef struct packed {
      logic        write;
      pll_reg_t    sel;
      logic [15:0] data;
   } step_op_t;

   function automatic step_op_t step_decode(input logic [2:0]  step,
                                            input logic [15:0] kp,
                                            input logic [15:0] ki,
                                            input logic [7:0]  n);
      step_op_t op;
      case (step)
         3'd0:    op = '{write: 1'b1, sel: REG_EN, data: 16'h0000};
         3'd1:    op = '{write: 1'b1, sel: REG_KP, data: kp};
         3'd2:    op = '{write: 1'b1, sel: REG_KI, data: ki};
         3'd3:    op = '{write: 1'b1, sel: REG_N,  data: {8'h00, n}};
         3'd4:    op = '{write: 1'b0, sel: REG_KP, data: kp};
         3'd5:    op = '{write: 1'b0, sel: REG_KI, data: ki};
         3'd6:    op = '{write: 1'b0, sel: REG_N,  data: {8'h00, n}};
         default: op = '{write: 1'b1, sel: REG_EN, data: 16'h0001};
      endcase
      return op;
   endfunction

endpackage

// File: rtl/ahb_pll_cfg_manager.sv
// Purpose : AHB-Lite manager that disables the PLL, writes kp/ki/n, reads
//           each back for verification and re-enables it, from one start pulse.
// Latency : 2 cycles per transfer plus wait states; done in cycle 17 minimum.
// Backpr. : address/data phases hold while HREADY=0; start ignored unless IDLE.
// Ports   : HCLK/HRESETn; start + cfg_kp/cfg_ki/cfg_n request; busy/done/
//           error/err_code/fail_step status; AHB-Lite manager bus.
module ahb_pll_cfg_manager
   import pll_cfg_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
   parameter logic [31:0] KP_OFFSET = PLL_KP_OFFSET,
   parameter logic [31:0] KI_OFFSET = PLL_KI_OFFSET,
   parameter logic [31:0] N_OFFSET  = PLL_N_OFFSET,
   parameter logic [31:0] EN_OFFSET = PLL_EN_OFFSET
) (
   input  logic        HCLK,
   input  logic        HRESETn,
   input  logic        start,
   input  logic [15:0] cfg_kp,
   input  logic [15:0] cfg_ki,
   input  logic [7:0]  cfg_n,
   output logic        busy,
   output logic        done,
   output logic        error,
   output logic [1:0]  err_code,
   output logic [2:0]  fail_step,
   output logic [31:0] HADDR,
   output logic [1:0]  HTRANS,
   output logic        HWRITE,
   output logic [2:0]  HSIZE,
   output logic [2:0]  HBURST,
   output logic [3:0]  HPROT,
   output logic        HMASTLOCK,
   output logic [31:0] HWDATA,
   input  logic [31:0] HRDATA,
   input  logic        HREADY,
   input  logic        HRESP
);

   cfg_state_t  state_q, state_d;
   logic [2:0]  step_q, step_d;
   logic [15:0] kp_q, kp_d;
   logic [15:0] ki_q, ki_d;
   logic [7:0]  n_q, n_d;
   logic        error_q, error_d;
   err_code_t   err_code_q, err_code_d;
   logic [2:0]  fail_step_q, fail_step_d;

   step_op_t    op;
   logic [31:0] reg_offset;
   logic [31:0] rd_mask;
   logic        rd_match;
   htrans_t     htrans;

   assign op = step_decode(step_q, kp_q, ki_q, n_q);

   always_comb begin
      case (op.sel)
         REG_KP:  reg_offset = KP_OFFSET;
         REG_KI:  reg_offset = KI_OFFSET;
         REG_N:   reg_offset = N_OFFSET;
         default: reg_offset = EN_OFFSET;
      endcase
   end

   // Only the implemented register bits take part in the readback check;
   // whatever the subordinate returns above them is ignored.
   assign rd_mask  = (op.sel == REG_N) ? 32'h0000_00FF : 32'h0000_FFFF;
   assign rd_match = ((HRDATA & rd_mask) == {16'h0000, op.data});

   always_ff @(posedge HCLK or negedge HRESETn) begin
      if (!HRESETn) begin
         state_q     <= ST_IDLE;
         step_q      <= 3'd0;
         kp_q        <= 16'h0000;
         ki_q        <= 16'h0000;
         n_q         <= 8'h00;
         error_q     <= 1'b0;
         err_code_q  <= ERR_NONE;
         fail_step_q <= 3'd0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         kp_q        <= kp_d;
         ki_q        <= ki_d;
         n_q         <= n_d;
         error_q     <= error_d;
         err_code_q  <= err_code_d;
         fail_step_q <= fail_step_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      kp_d        = kp_q;
      ki_d        = ki_q;
      n_d         = n_q;
      error_d     = error_q;
      err_code_d  = err_code_q;
      fail_step_d = fail_step_q;
      htrans      = HTRANS_IDLE;
      HADDR       = 32'h0000_0000;
      HWRITE      = 1'b0;
      HWDATA      = 32'h0000_0000;

      case (state_q)
         ST_IDLE: begin
            if (start) begin
               kp_d        = cfg_kp;
               ki_d        = cfg_ki;
               n_d         = cfg_n;
               error_d     = 1'b0;
               err_code_d  = ERR_NONE;
               fail_step_d = 3'd0;
               step_d      = 3'd0;
               state_d     = ST_ADDR;
            end
         end

         ST_ADDR: begin
            htrans = HTRANS_NONSEQ;
            HADDR  = BASE_ADDR + reg_offset;
            HWRITE = op.write;
            if (HREADY) begin
               state_d = ST_DATA;
            end
         end

         ST_DATA: begin
            if (op.write) begin
               HWDATA = {16'h0000, op.data};
            end
            // First ERROR cycle (HREADY=0) just waits; the second one ends
            // the sequence so no further transfer reaches the PLL.
            if (HRESP) begin
               if (HREADY) begin
                  error_d     = 1'b1;
                  err_code_d  = ERR_HRESP;
                  fail_step_d = step_q;
                  state_d     = ST_FIN;
               end
            end else if (HREADY) begin
               if (!op.write && !rd_match) begin
                  error_d     = 1'b1;
                  err_code_d  = ERR_MISMATCH;
                  fail_step_d = step_q;
                  state_d     = ST_FIN;
               end else if (step_q == 3'd7) begin
                  state_d = ST_FIN;
               end else begin
                  step_d  = step_q + 3'd1;
                  state_d = ST_ADDR;
               end
            end
         end

         ST_FIN: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign busy      = (state_q == ST_ADDR) || (state_q == ST_DATA);
   assign done      = (state_q == ST_FIN);
   assign error     = error_q;
   assign err_code  = err_code_q;
   assign fail_step = fail_step_q;
   assign HTRANS    = htrans;
   assign HSIZE     = HSIZE_WORD;
   assign HBURST    = HBURST_SINGLE;
   assign HPROT     = HPROT_PRIV_DATA;
   assign HMASTLOCK = 1'b0;

endmodule

// File: tb/tb_ahb_pll_cfg_manager.sv
// Directed bench for ahb_pll_cfg_manager with a behavioural PLL subordinate
// that supports wait states, two-cycle ERROR responses, readback corruption
// and upper-bit noise on HRDATA.
module tb_ahb_pll_cfg_manager;

   logic        HCLK = 1'b0;
   logic        HRESETn;
   logic        start;
   logic [15:0] cfg_kp, cfg_ki;
   logic [7:0]  cfg_n;
   logic        busy, done, error;
   logic [1:0]  err_code;
   logic [2:0]  fail_step;
   logic [31:0] HADDR;
   logic [1:0]  HTRANS;
   logic        HWRITE;
   logic [2:0]  HSIZE, HBURST;
   logic [3:0]  HPROT;
   logic        HMASTLOCK;
   logic [31:0] HWDATA;
   logic [31:0] HRDATA = 32'h0;
   logic        HREADY = 1'b1;
   logic        HRESP  = 1'b0;

   int nvec  = 0;
   int nfail = 0;

   always #5 HCLK = ~HCLK;

   ahb_pll_cfg_manager dut (
      .HCLK(HCLK), .HRESETn(HRESETn), .start(start),
      .cfg_kp(cfg_kp), .cfg_ki(cfg_ki), .cfg_n(cfg_n),
      .busy(busy), .done(done), .error(error), .err_code(err_code),
      .fail_step(fail_step), .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE),
      .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK),
      .HWDATA(HWDATA), .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP)
   );

   // ---------------- subordinate model ----------------
   logic [31:0] regs [4] = '{default: 32'h0};
   logic [31:0] log_addr  [64];
   logic        log_wr    [64];
   logic [31:0] log_wdata [64];
   int          log_n      = 0;
   int          ws         = 0;
   int          err_at     = -1;
   int          bad_at     = -1;
   int          stall_cnt  = 0;
   int          stall_viol = 0;
   logic        dph = 1'b0, erph = 1'b0, first = 1'b0;
   int          wcnt = 0, cur = 0;
   logic [31:0] cur_addr = 32'h0;
   logic        cur_wr = 1'b0;
   logic [31:0] snap_addr = 32'h0, snap_wdata = 32'h0;
   logic [1:0]  snap_trans = 2'b0;

   // Decides bus responses at the negedge for the following posedge.
   always @(negedge HCLK) begin
      if (!HRESETn) begin
         dph = 1'b0; erph = 1'b0; HREADY = 1'b1; HRESP = 1'b0;
      end else begin
         if (dph) begin
            if (first) begin
               snap_addr = HADDR; snap_wdata = HWDATA; snap_trans = HTRANS; first = 1'b0;
            end
            if (HADDR !== snap_addr || HWDATA !== snap_wdata || HTRANS !== snap_trans)
               stall_viol++;
            if (wcnt > 0) begin
               HREADY = 1'b0; HRESP = 1'b0; wcnt--; stall_cnt++;
            end else if (cur == err_at && !erph) begin
               HREADY = 1'b0; HRESP = 1'b1; erph = 1'b1;
            end else if (erph) begin
               HREADY = 1'b1; HRESP = 1'b1; erph = 1'b0; dph = 1'b0;
            end else begin
               HREADY = 1'b1; HRESP = 1'b0; dph = 1'b0;
               if (cur_wr) begin
                  regs[cur_addr[3:2]] = HWDATA;
                  if (cur < 64) log_wdata[cur] = HWDATA;
               end else begin
                  HRDATA = regs[cur_addr[3:2]] |
                           ((cur_addr[3:2] == 2'd2) ? 32'hABCD_EF00 : 32'hABCD_0000);
                  if (cur == bad_at) HRDATA[15:0] = 16'h0057;
               end
            end
         end else begin
            HREADY = 1'b1; HRESP = 1'b0;
         end
         if (!dph && HREADY && HTRANS == 2'b10) begin
            cur = log_n;
            if (log_n < 64) begin
               log_addr[log_n] = HADDR; log_wr[log_n] = HWRITE;
            end
            log_n++;
            cur_addr = HADDR; cur_wr = HWRITE; dph = 1'b1; first = 1'b1; wcnt = ws;
         end
      end
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      nvec++;
      assert (obs === exp)
      else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] t1_addr(input int i);
      case (i)
         0: return 32'hC;  1: return 32'h0;  2: return 32'h4;  3: return 32'h8;
         4: return 32'h0;  5: return 32'h4;  6: return 32'h8;  default: return 32'hC;
      endcase
   endfunction

   function automatic logic [31:0] t1_wdata(input int i);
      case (i)
         1: return 32'h1234;  2: return 32'h0056;  3: return 32'h0020;
         7: return 32'h0001;  default: return 32'h0;
      endcase
   endfunction

   // Start pulse in cycle 0; returns the cycle in which done was seen (or the
   // cycle stop_at, if nonzero). Extra start pulses in cycles p1/p2 carry junk cfg.
   task automatic go(input logic [15:0] kp, input logic [15:0] ki, input logic [7:0] n,
                     input int p1, input int p2, input int stop_at, output int cyc);
      @(posedge HCLK); #1;
      cfg_kp = kp; cfg_ki = ki; cfg_n = n; start = 1'b1;
      cyc = 0;
      do begin
         @(posedge HCLK); #1;
         cyc++;
         if (cyc == 1) begin
            check("busy_after_start", busy, 1);
            check("error_cleared", error, 0);
         end
         if (cyc == p1 || cyc == p2) begin
            start = 1'b1; cfg_kp = 16'hFFFF; cfg_ki = 16'hEEEE; cfg_n = 8'hDD;
         end else begin
            start = 1'b0;
         end
      end while (!done && cyc < 400 && !(stop_at > 0 && cyc == stop_at));
      start = 1'b0;
      if (stop_at == 0) check("done_seen", done, 1);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      int cyc, base, s0;
      HRESETn = 1'b0; start = 1'b0; cfg_kp = 16'h0; cfg_ki = 16'h0; cfg_n = 8'h0;
      #2;
      check("rst_busy", busy, 0);       check("rst_done", done, 0);
      check("rst_error", error, 0);     check("rst_err_code", err_code, 0);
      check("rst_fail_step", fail_step, 0);
      check("rst_htrans", HTRANS, 0);   check("rst_haddr", HADDR, 0);
      check("rst_hwrite", HWRITE, 0);   check("rst_hwdata", HWDATA, 0);
      check("hsize", HSIZE, 3'b010);    check("hburst", HBURST, 3'b000);
      check("hprot", HPROT, 4'b0011);   check("hmastlock", HMASTLOCK, 0);
      #20 HRESETn = 1'b1;

      // 1: zero-wait happy path
      base = log_n;
      go(16'h1234, 16'h0056, 8'h20, -1, -1, 0, cyc);
      check("t1_latency", cyc, 17);
      check("t1_error", error, 0);
      check("t1_err_code", err_code, 0);
      check("t1_ntrans", log_n - base, 8);
      for (int i = 0; i < 8; i++) begin
         check($sformatf("t1_addr%0d", i), log_addr[base + i], t1_addr(i));
         check($sformatf("t1_wr%0d", i), log_wr[base + i], (i < 4 || i == 7) ? 1 : 0);
         if (i < 4 || i == 7)
            check($sformatf("t1_wdata%0d", i), log_wdata[base + i], t1_wdata(i));
      end
      check("t1_en_reg", regs[3], 32'h1);
      @(posedge HCLK); #1;
      check("t1_done_1cyc", done, 0);
      check("t1_busy_idle", busy, 0);

      // 2: three wait states in every data phase
      ws = 3; base = log_n; s0 = stall_cnt;
      go(16'h0A0B, 16'h0C0D, 8'h0E, -1, -1, 0, cyc);
      ws = 0;
      check("t2_latency", cyc, 41);
      check("t2_error", error, 0);
      check("t2_stalls", stall_cnt - s0, 24);
      check("t2_stable", stall_viol, 0);
      check("t2_ntrans", log_n - base, 8);
      check("t2_kp_reg", regs[0], 32'h0A0B);

      // 3: two-cycle ERROR response on step 2
      base = log_n; err_at = log_n + 2;
      go(16'h1111, 16'h2222, 8'h33, -1, -1, 0, cyc);
      err_at = -1;
      check("t3_latency", cyc, 8);
      check("t3_error", error, 1);
      check("t3_err_code", err_code, 1);
      check("t3_fail_step", fail_step, 2);
      check("t3_ntrans", log_n - base, 3);
      check("t3_en_off", regs[3], 32'h0);
      check("t3_ki_untouched", regs[1], 32'h0C0D);

      // 4: ki readback corrupted; kp readback carries upper-bit noise
      base = log_n; bad_at = log_n + 5;
      go(16'h4321, 16'h0056, 8'h10, -1, -1, 0, cyc);
      bad_at = -1;
      check("t4_latency", cyc, 13);
      check("t4_error", error, 1);
      check("t4_err_code", err_code, 2);
      check("t4_fail_step", fail_step, 5);
      check("t4_ntrans", log_n - base, 6);
      check("t4_en_off", regs[3], 32'h0);
      @(posedge HCLK); #1;
      check("t4_err_sticky", error, 1);
      check("t4_code_sticky", err_code, 2);

      // 5: start pulses mid-run and in FIN are ignored
      base = log_n;
      go(16'hBEEF, 16'h0102, 8'h7F, 3, 10, 0, cyc);
      check("t5_latency", cyc, 17);
      check("t5_error", error, 0);
      check("t5_ntrans", log_n - base, 8);
      check("t5_kp_wr", log_wdata[base + 1], 32'hBEEF);
      check("t5_ki_wr", log_wdata[base + 2], 32'h0102);
      check("t5_n_wr", log_wdata[base + 3], 32'h7F);
      start = 1'b1;
      @(posedge HCLK); #1;
      start = 1'b0;
      check("t5_fin_start_busy", busy, 0);
      check("t5_fin_start_done", done, 0);

      // 6: reset during step 4 data phase, then a clean restart
      base = log_n;
      go(16'h5555, 16'h6666, 8'h77, -1, -1, 10, cyc);
      check("t6_busy_pre", busy, 1);
      check("t6_ntrans_pre", log_n - base, 5);
      #1 HRESETn = 1'b0;
      #1;
      check("t6_busy_rst", busy, 0);    check("t6_htrans_rst", HTRANS, 0);
      check("t6_haddr_rst", HADDR, 0);  check("t6_hwrite_rst", HWRITE, 0);
      check("t6_hwdata_rst", HWDATA, 0); check("t6_done_rst", done, 0);
      check("t6_error_rst", error, 0);
      repeat (2) @(negedge HCLK);
      HRESETn = 1'b1;
      base = log_n;
      go(16'h0F0F, 16'h00F0, 8'h0F, -1, -1, 0, cyc);
      check("t6_latency", cyc, 17);
      check("t6_first_addr", log_addr[base], 32'hC);
      check("t6_first_wdata", log_wdata[base], 32'h0);
      check("t6_error", error, 0);
      check("t6_kp_reg", regs[0], 32'h0F0F);
      check("t6_en_reg", regs[3], 32'h1);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
      $finish;
   end

endmodule

// File: doc/ahb_pll_cfg_manager.md
Name: ahb_pll_cfg_manager

Overview:
AHB-Lite manager that programs the PLL register block (kp, ki, n, enable) from a local request interface. One start pulse runs a fixed sequence: disable the PLL, write kp/ki/n, read back and verify each one, then re-enable. It sits on the bus-initiator side of the PLL subordinate. It lets a boot controller or test harness reconfigure the PLL without a CPU.

Parameters:
BASE_ADDR, 32'h0000_0000, subordinate base address
KP_OFFSET, 32'h0, kp register offset (bits [15:0])
KI_OFFSET, 32'h4, ki register offset (bits [15:0])
N_OFFSET, 32'h8, n register offset (bits [7:0])
EN_OFFSET, 32'hC, enable register offset (bit 0)

Ports:
HCLK  in  1  bus clock
HRESETn  in  1  asynchronous active-low reset
start  in  1  one-cycle request pulse; ignored while busy
cfg_kp  in  16  kp value, captured on accepted start
cfg_ki  in  16  ki value, captured on accepted start
cfg_n  in  8  n value, captured on accepted start
busy  out  1  sequence in progress
done  out  1  one-cycle pulse at sequence end (success or failure)
error  out  1  sticky failure flag; cleared on next accepted start
err_code  out  2  0 none, 1 HRESP error, 2 readback mismatch
fail_step  out  3  step index at which failure occurred
HADDR  out  32  address
HTRANS  out  2  IDLE=2'b00 / NONSEQ=2'b10 only
HWRITE  out  1  write strobe
HSIZE  out  3  always 3'b010 (word)
HBURST  out  3  always 3'b000 (SINGLE)
HPROT  out  4  always 4'b0011
HMASTLOCK  out  1  always 0
HWDATA  out  32  write data, zero-extended
HRDATA  in  32  read data
HREADY  in  1  transfer complete / stall
HRESP  in  1  0 OKAY, 1 ERROR

Behaviour:
- Reset (async, HRESETn=0): state IDLE, step=0. busy/done/error=0, err_code=0, fail_step=0. HTRANS=IDLE, HADDR=0, HWRITE=0, HWDATA=0.
- Step table (index: op, offset, data):
  - 0: W EN=0
  - 1: W KP=cfg_kp
  - 2: W KI=cfg_ki
  - 3: W N=cfg_n
  - 4: R KP
  - 5: R KI
  - 6: R N
  - 7: W EN=1
- FSM states IDLE, ADDR, DATA, FIN.
- IDLE: start=1 latches cfg_* and clears error/err_code/fail_step. Sets busy=1, step=0, and goes to ADDR next cycle.
- ADDR: drives HTRANS=NONSEQ, HADDR=BASE_ADDR+offset, HWRITE per step. Holds all of these until HREADY=1, then goes to DATA.
- DATA: drives HTRANS=IDLE. HWDATA holds step data for the whole data phase. Transfers never overlap: no pipelining; address of step k+1 is issued only after data phase k completes. Exits on one of three conditions:
  - HREADY=1 and HRESP=0: OKAY. On a read step, compare HRDATA masked to register width against the latched value; upper bits ignored. Mismatch → error=1, err_code=2, fail_step=step, go FIN. Otherwise step=7 → FIN, else step+1 → ADDR.
  - HRESP=1 with HREADY=0 (first error cycle): stays in DATA, issues no new transfer.
  - HRESP=1 with HREADY=1 (second error cycle): error=1, err_code=1, fail_step=step, go FIN.
- Any failure skips all remaining steps, so the PLL stays disabled.
- FIN: done=1 for exactly one cycle, busy=0, return to IDLE. error/err_code/fail_step hold their values.
- Minimum latency with zero wait states: start at cycle 0, done asserted in cycle 17 (8 transfers × 2 cycles, plus 1).
- start asserted while busy or in FIN: ignored, no queuing.
- Reset mid-sequence: immediate return to reset values. The subordinate's partial state is not restored.
- busy=1 from the cycle after accepted start until FIN inclusive is deasserted.

Decomposition:
- Shared package pll_cfg_pkg holds:
  - htrans_t enum (IDLE, BUSY, NONSEQ, SEQ)
  - HSIZE_WORD, HBURST_SINGLE constants
  - register offset localparams (shared with the subordinate)
  - err_code_t enum
  - cfg_state_t enum
- Single module; step-table decode is a combinational function in the package. No sub-module is needed.

Test Plan:
1. Zero-wait happy path: start with kp=16'h1234, ki=16'h0056, n=8'h20, subordinate model echoes writes → 8 transfers to 0xC,0x0,0x4,0x8,0x0,0x4,0x8,0xC with data 0,1234,56,20,-,-,-,1. done in cycle 17, error=0.
2. Wait states: HREADY low for 3 cycles in every data phase → HADDR/HTRANS/HWDATA stable throughout each stall. Total latency 17+24 cycles, success.
3. Bus error on step 2: two-cycle ERROR response → no further NONSEQ, error=1, err_code=1, fail_step=2, done pulse; EN=1 never written.
4. Readback mismatch: model returns ki=16'h0057 on step 5 → err_code=2, fail_step=5, step 6/7 skipped. Upper-bit noise on HRDATA[31:16] for kp read does not cause a mismatch.
5. start pulsed at cycles 3 and 10 during a run → ignored, latched config unchanged. New start after done clears error and runs again.
6. HRESETn asserted during step 4 data phase → outputs at reset values asynchronously (before next HCLK edge). Next start restarts from step 0.
